// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster clock-gate / reset / AXI-isolation sequencer.
// One independent FSM per cluster enforces a safe power-up and power-down order.
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters   = 5,
    parameter int unsigned ClkWaitCycles = 8,
    parameter int unsigned RstWaitCycles = 4,
    parameter int unsigned IsoTimeout    = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] cluster_en_i,
    input  logic [NumClusters-1:0] cluster_iso_ack_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic [NumClusters-1:0] cluster_iso_o,
    output logic [NumClusters-1:0] cluster_busy_o,
    output logic [NumClusters-1:0] cluster_on_o,
    output logic [NumClusters-1:0] cluster_err_o
);

    localparam int unsigned MaxCR   = (ClkWaitCycles > RstWaitCycles) ? ClkWaitCycles : RstWaitCycles;
    localparam int unsigned MaxWait = (MaxCR > IsoTimeout) ? MaxCR : IsoTimeout;
    localparam int unsigned CntW    = $clog2(MaxWait + 1);

    localparam logic [CntW-1:0] ClkLast = CntW'(ClkWaitCycles - 1);
    localparam logic [CntW-1:0] RstLast = CntW'(RstWaitCycles - 1);
    localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);

    typedef enum logic [2:0] {
        OFF,
        CLK_ON,
        RST_REL,
        DEISO,
        ON,
        ISO,
        RST_HOLD
    } state_e;

    for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            clk_en_q, clk_en_d;
        logic            rst_n_q, rst_n_d;
        logic            iso_q, iso_d;
        logic            busy_q, busy_d;
        logic            on_q, on_d;
        logic            err_q, err_d;
        logic            err_set;

        always_comb begin
            state_d = state_q;
            err_set = 1'b0;

            unique case (state_q)
                OFF:      if (cluster_en_i[g]) state_d = CLK_ON;
                CLK_ON:   if (cnt_q == ClkLast) state_d = RST_REL;
                RST_REL:  if (cnt_q == RstLast) state_d = DEISO;
                DEISO: begin
                    if (!cluster_iso_ack_i[g]) begin
                        state_d = ON;
                    end else if (cnt_q == IsoLast) begin
                        err_set = 1'b1;
                    end
                end
                ON:       if (!cluster_en_i[g]) state_d = ISO;
                ISO: begin
                    if (cluster_iso_ack_i[g]) begin
                        state_d = RST_HOLD;
                    end else if (cnt_q == IsoLast) begin
                        err_set = 1'b1;
                        state_d = RST_HOLD;
                    end
                end
                RST_HOLD: if (cnt_q == RstLast) state_d = OFF;
                default:  state_d = OFF;
            endcase

            // Counter restarts on every state entry; a stuck DEISO parks it at the timeout value.
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (state_q == OFF || state_q == ON) begin
                cnt_d = '0;
            end else if (state_q == DEISO && cnt_q == IsoLast) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end

            // Outputs are decoded from the next state so they register on the same edge.
            clk_en_d = (state_d != OFF);
            rst_n_d  = (state_d == RST_REL) || (state_d == DEISO) ||
                       (state_d == ON)      || (state_d == ISO);
            iso_d    = !((state_d == DEISO) || (state_d == ON));
            busy_d   = (state_d != OFF) && (state_d != ON);
            on_d     = (state_d == ON);
            err_d    = err_set | (err_q & ~err_clr_i[g]);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= OFF;
                cnt_q    <= '0;
                clk_en_q <= 1'b0;
                rst_n_q  <= 1'b0;
                iso_q    <= 1'b1;
                busy_q   <= 1'b0;
                on_q     <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                clk_en_q <= clk_en_d;
                rst_n_q  <= rst_n_d;
                iso_q    <= iso_d;
                busy_q   <= busy_d;
                on_q     <= on_d;
                err_q    <= err_d;
            end
        end

        assign cluster_clk_en_o[g] = clk_en_q;
        assign cluster_rst_no[g]   = rst_n_q;
        assign cluster_iso_o[g]    = iso_q;
        assign cluster_busy_o[g]   = busy_q;
        assign cluster_on_o[g]     = on_q;
        assign cluster_err_o[g]    = err_q;
    end

endmodule
